// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous-read memory.
// Port 0 is the CPU datapath, port 1 the loader/debug port; one access in flight at a time.
module mem_port_arbiter #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam int CNT_W = 3;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              last_q, last_d;
   logic              grant_q, grant_d;
   logic              sel;
   logic              rd_cap;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              busy_q, busy_d;
   logic              p0_ack_q, p0_ack_d;
   logic              p1_ack_q, p1_ack_d;
   logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

   // last_q resets to 1 so that port 0 wins the first contention.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         last_q      <= 1'b1;
         grant_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         p0_ack_q    <= 1'b0;
         p1_ack_q    <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         last_q      <= last_d;
         grant_q     <= grant_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         p0_ack_q    <= p0_ack_d;
         p1_ack_q    <= p1_ack_d;
         p0_rdata_q  <= p0_rdata_d;
         p1_rdata_q  <= p1_rdata_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      last_d      = last_q;
      grant_d     = grant_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      sel         = 1'b0;
      case (state_q)
         IDLE: begin
            if (p0_req || p1_req) begin
               sel         = (p0_req && p1_req) ? ~last_q : p1_req;
               grant_d     = sel;
               last_d      = sel;
               we_d        = sel ? p1_we : p0_we;
               mem_addr_d  = sel ? p1_addr : p0_addr;
               mem_wdata_d = sel ? p1_wdata : p0_wdata;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CNT_W'(MEM_LAT - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered in that state's cycle.
   always_comb begin
      mem_en_d   = (state_d == ISSUE);
      mem_we_d   = (state_d == ISSUE) && we_d;
      busy_d     = (state_d != IDLE);
      p0_ack_d   = (state_d == DONE) && !grant_d;
      p1_ack_d   = (state_d == DONE) && grant_d;
      rd_cap     = (state_q == WAIT) && (cnt_q == '0) && !we_q;
      p0_rdata_d = (rd_cap && !grant_q) ? mem_rdata : p0_rdata_q;
      p1_rdata_d = (rd_cap && grant_q)  ? mem_rdata : p1_rdata_q;
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign grant     = grant_q;
   assign p0_ack    = p0_ack_q;
   assign p1_ack    = p1_ack_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 256x16 unified memory between two requesters.
- Port 0 is the multicycle CPU datapath, for instruction fetch and load/store.
- Port 1 is the program loader/debug port.
- Sits between the requesters and the memory block, sequences each access through a small FSM, and returns data with a one-cycle ack handshake.
- Round-robin on contention, so neither port starves.

Parameters:
DATA_W, 16, data word width
ADDR_W, 8, memory word-address width
MEM_LAT, 1, memory synchronous-read latency in cycles (legal 1..7)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
p0_req  in  1  port 0 access request; held with p0_we/addr/wdata stable until p0_ack
p0_we  in  1  port 0 write enable (1 = write, 0 = read)
p0_addr  in  ADDR_W  port 0 word address
p0_wdata  in  DATA_W  port 0 write data
p0_ack  out  1  port 0 access complete, one-cycle pulse
p0_rdata  out  DATA_W  port 0 read data; valid while p0_ack is high, held until the next port 0 read completes
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  as port 0, for port 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the edge that samples mem_en
busy  out  1  high in any state other than IDLE
grant  out  1  index of the port owning the current or most recent access

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, acks, rdatas, busy, grant.
  - last_served is set to 1, so port 0 wins the first contention.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - With no req, stay in IDLE.
  - With exactly one req, grant that port.
  - With both req, grant the port != last_served.
  - On grant, latch addr, wdata and we into the mem_* registers; set grant and last_served; go to ISSUE.
- ISSUE:
  - mem_en = 1; mem_we = latched we.
  - Lasts exactly one cycle.
  - Load counter with MEM_LAT-1; go to WAIT.
- WAIT:
  - mem_en = mem_we = 0.
  - If counter == 0: on a read, capture mem_rdata into the granted port's rdata, then go to DONE. Otherwise decrement.
- DONE:
  - Granted port's ack = 1 for exactly this cycle.
  - req inputs are ignored; go to IDLE.
- Handshake:
  - The requester samples ack at the edge ending DONE and drops or changes req at that edge.
  - A req still high in the following IDLE cycle is a new access (back-to-back allowed).
- Latency: if req is sampled in IDLE at edge E, ack is high in the cycle after edge E+MEM_LAT+1. This is 2 cycles for MEM_LAT=1, and 1+MEM_LAT+1 states per access.
- A write does not modify the port's rdata.
- The ungranted port's signals are ignored until the next IDLE.
- Requests are never queued; a req dropped before grant is simply never served.
- Reset mid-access:
  - The access is aborted with no ack.
  - The write completes only if mem_en was already sampled by memory before reset asserted.
- A req asserted during reset is evaluated at the first IDLE edge after reset deasserts.
- Addresses wrap naturally within ADDR_W; the arbiter performs no address arithmetic.

Test Plan:
1. Reset, then p0 read addr 0x10 (memory holds 0x1234), MEM_LAT=1 -> mem_en high one cycle with mem_addr=0x10; p0_ack pulses 2 cycles after the req sampling edge with p0_rdata=0x1234; busy low afterwards.
2. p1 write addr 0x20 data 0xBEEF, then p0 read 0x20 -> mem_we=1 only in ISSUE; p1_ack pulses and p1_rdata is unchanged; p0_rdata=0xBEEF.
3. p0 and p1 req in the same cycle, both held for 3 back-to-back accesses -> grant order 0,1,0 with acks alternating; no double service of one access; 4 cycles per access.
4. Reset asserted during WAIT of a p0 read -> outputs zero immediately, no p0_ack; after release with p0_req still high, a fresh access completes normally with port 0 winning contention against p1.
5. MEM_LAT=3, p0 read 0xFF -> ack 4 cycles after the sampling edge; mem_en high one cycle only; rdata matches memory[0xFF].
6. p1 drops req while p0 is being served -> p1 never granted, no p1_ack; FSM returns to IDLE with busy=0.
